// File: rtl/pc_sequencer.sv
// Phase-FSM instruction sequencer (FETCH/DECODE/EXEC/MEM/WB/NEXT) driving IR, memory, regfile and PC strobes.
// Optional performance counters (instr_retired, cycle_count) are enabled by defining SEQ_PERF_EN.
module pc_sequencer #(
  parameter int D           = 12,
  parameter int EXEC_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         halt,
  input  logic         is_mem,
  input  logic         mem_ready,
  input  logic         branch_taken,
  input  logic [D-1:0] branch_target,
  output logic         ir_load,
  output logic         mem_req,
  output logic         reg_we,
  output logic         pc_inc,
  output logic         pc_load,
  output logic [D-1:0] pc_target,
  output logic [2:0]   state,
`ifdef SEQ_PERF_EN
  output logic [15:0]  instr_retired,
  output logic [15:0]  cycle_count,
`endif
  output logic         busy,
  output logic         halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_NEXT   = 3'd6,
    S_HALTED = 3'd7
  } state_e;

  localparam int              CW        = $clog2(EXEC_CYCLES + 1);
  localparam logic [CW-1:0]   EXEC_LAST = CW'(EXEC_CYCLES);
  localparam logic [CW-1:0]   EXEC_ONE  = CW'(1);

  state_e         state_q;
  logic [CW-1:0]  exec_cnt_q;
  logic           branch_q;
  logic [D-1:0]   pc_target_q;
  logic           ir_load_q;
  logic           mem_req_q;
  logic           reg_we_q;
  logic           pc_inc_q;
  logic           pc_load_q;
  logic           busy_q;
  logic           halted_q;

  // Each strobe register is loaded with the value that belongs to the state being
  // entered, so outputs are a registered decode of state with no output glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      exec_cnt_q  <= '0;
      branch_q    <= 1'b0;
      pc_target_q <= '0;
      ir_load_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      reg_we_q    <= 1'b0;
      pc_inc_q    <= 1'b0;
      pc_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch reads the
      // pre-edge state and the default strobe clears below cannot race the case.
      ir_load_q <= 1'b0;
      mem_req_q <= 1'b0;
      reg_we_q  <= 1'b0;
      pc_inc_q  <= 1'b0;
      pc_load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_FETCH;
            ir_load_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (halt) begin
            state_q  <= S_HALTED;
            busy_q   <= 1'b0;
            halted_q <= 1'b1;
          end else begin
            state_q    <= S_EXEC;
            exec_cnt_q <= EXEC_ONE;
          end
        end
        S_EXEC: begin
          if (exec_cnt_q == EXEC_LAST) begin
            exec_cnt_q <= '0;
            branch_q   <= branch_taken;
            if (branch_taken) pc_target_q <= branch_target;
            if (is_mem) begin
              state_q   <= S_MEM;
              mem_req_q <= 1'b1;
            end else begin
              state_q  <= S_WB;
              reg_we_q <= 1'b1;
            end
          end else begin
            exec_cnt_q <= exec_cnt_q + EXEC_ONE;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            state_q  <= S_WB;
            reg_we_q <= 1'b1;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        S_WB: begin
          state_q   <= S_NEXT;
          pc_inc_q  <= ~branch_q;
          pc_load_q <= branch_q;
        end
        S_NEXT: begin
          state_q   <= S_FETCH;
          ir_load_q <= 1'b1;
          branch_q  <= 1'b0;
        end
        S_HALTED: state_q <= S_HALTED;
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign ir_load   = ir_load_q;
  assign mem_req   = mem_req_q;
  assign reg_we    = reg_we_q;
  assign pc_inc    = pc_inc_q;
  assign pc_load   = pc_load_q;
  assign pc_target = pc_target_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

`ifdef SEQ_PERF_EN
  logic [15:0] instr_retired_q;
  logic [15:0] cycle_count_q;

  // Both counters saturate rather than wrap so a long run never reads as a short one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_retired_q <= '0;
      cycle_count_q   <= '0;
    end else begin
      if (state_q == S_NEXT && instr_retired_q != 16'hFFFF)
        instr_retired_q <= instr_retired_q + 16'd1;
      if (busy_q && cycle_count_q != 16'hFFFF)
        cycle_count_q <= cycle_count_q + 16'd1;
    end
  end

  assign instr_retired = instr_retired_q;
  assign cycle_count   = cycle_count_q;
`endif

  pc_strobes_exclusive: assert property (@(posedge clk) disable iff (!reset) !(pc_inc && pc_load));
  halted_not_busy:      assert property (@(posedge clk) disable iff (!reset) !(halted && busy));

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed table, hand-written corner sequences and random instructions
// checked against a position-in-instruction schedule model.
module tb_pc_sequencer;
  localparam int D = 12;
  localparam int E = 4;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2, ST_EXEC = 3'd3,
                         ST_MEM = 3'd4, ST_WB = 3'd5, ST_NEXT = 3'd6, ST_HALTED = 3'd7;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         halt = 1'b0;
  logic         is_mem = 1'b0;
  logic         mem_ready = 1'b0;
  logic         branch_taken = 1'b0;
  logic [D-1:0] branch_target = '0;
  logic         ir_load, mem_req, reg_we, pc_inc, pc_load, busy, halted;
  logic [D-1:0] pc_target;
  logic [2:0]   state;
`ifdef SEQ_PERF_EN
  logic [15:0]  instr_retired, cycle_count;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.D(D), .EXEC_CYCLES(E)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .is_mem(is_mem),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .branch_target(branch_target),
    .ir_load(ir_load), .mem_req(mem_req), .reg_we(reg_we), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_target(pc_target), .state(state),
`ifdef SEQ_PERF_EN
    .instr_retired(instr_retired), .cycle_count(cycle_count),
`endif
    .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic ir, mreq, rwe, pinc, pload, bsy, hlt;
  } out_t;

  typedef struct {
    bit           im;
    int           m;
    bit           br;
    logic [D-1:0] tgt;
    int           exp_len;
    int           exp_mreq;
    bit           exp_load;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic out_t dut_out();
    return {state, ir_load, mem_req, reg_we, pc_inc, pc_load, busy, halted};
  endfunction

  // Expected outputs p cycles after entering FETCH: FETCH, DECODE, E x EXEC,
  // m x MEM (mem instrs only), WB, NEXT, then FETCH of the following instruction.
  function automatic out_t model_at(int p, bit im, int m, bit br);
    out_t o = '0;
    int   wb = E + 2 + (im ? m : 0);
    o.bsy = 1'b1;
    if (p == 0 || p >= wb + 2) begin o.st = ST_FETCH; o.ir = 1'b1; end
    else if (p == 1)           o.st = ST_DECODE;
    else if (p <= E + 1)       o.st = ST_EXEC;
    else if (p < wb)           begin o.st = ST_MEM; o.mreq = 1'b1; end
    else if (p == wb)          begin o.st = ST_WB; o.rwe = 1'b1; end
    else begin o.st = ST_NEXT; o.pinc = !br; o.pload = br; end
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Inputs are random except in the cycle where the sequencer samples them.
  task automatic drive(input int p, input bit im, input int m, input bit br, input logic [D-1:0] tgt);
    start         = 1'($urandom);
    halt          = (p == 1) ? 1'b0 : 1'($urandom);
    is_mem        = (p == E + 1) ? im : 1'($urandom);
    branch_taken  = (p == E + 1) ? br : 1'($urandom);
    branch_target = (p == E + 1) ? tgt : D'($urandom);
    if (im && p >= E + 2 && p < E + 2 + m) mem_ready = (p == E + 1 + m);
    else                                   mem_ready = 1'($urandom);
  endtask

  task automatic run_instr(input bit im, input int m, input bit br, input logic [D-1:0] tgt,
                           input int abort_at, output int len, output int mreq_cnt,
                           output bit saw_load, output logic [D-1:0] saw_tgt);
    out_t exp;
    len = 0; mreq_cnt = 0; saw_load = 1'b0; saw_tgt = '0;
    for (int p = 0; p < 80; p++) begin
      if (p > 0 && state == ST_FETCH) begin
        len = p;
        break;
      end
      exp = model_at(p, im, m, br);
      check($sformatf("outputs p%0d", p), 32'(dut_out()), 32'(exp));
      if (exp.pload) check("pc_target in NEXT", 32'(pc_target), 32'(tgt));
      if (mem_req) mreq_cnt++;
      if (pc_load) begin saw_load = 1'b1; saw_tgt = pc_target; end
      if (p == abort_at) return;
      drive(p, im, m, br, tgt);
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  initial begin
    vec_t         tbl [6];
    logic [2:0]   seq [9];
    int           len, mc;
    bit           sl;
    logic [D-1:0] st;

    tbl[0] = '{0, 0, 0, 12'h000,  8, 0, 0};
    tbl[1] = '{0, 0, 1, 12'h0A5,  8, 0, 1};
    tbl[2] = '{0, 0, 0, 12'h3C3,  8, 0, 0};
    tbl[3] = '{1, 3, 0, 12'h000, 11, 3, 0};
    tbl[4] = '{1, 1, 0, 12'h000,  9, 1, 0};
    tbl[5] = '{1, 2, 1, 12'hFFF, 10, 2, 1};
    seq = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd5, 3'd6, 3'd1};

    #3 reset = 1'b0;
    #1 check("reset outputs", {dut_out(), pc_target}, 32'd0);
    do_reset();
    check("idle after reset", 32'(dut_out()), 32'd0);

    // Single plain instruction with the exact state trace.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("trace state %0d", i), 32'(state), 32'(seq[i]));
      check($sformatf("trace pc_inc %0d", i), 32'(pc_inc), 32'(i == 7));
      if (i < 8) step();
    end

    foreach (tbl[i]) begin
      run_instr(tbl[i].im, tbl[i].m, tbl[i].br, tbl[i].tgt, -1, len, mc, sl, st);
      check($sformatf("tbl%0d latency", i), 32'(len), 32'(tbl[i].exp_len));
      check($sformatf("tbl%0d mem_req cycles", i), 32'(mc), 32'(tbl[i].exp_mreq));
      check($sformatf("tbl%0d pc_load", i), 32'(sl), 32'(tbl[i].exp_load));
      if (tbl[i].exp_load) check($sformatf("tbl%0d target", i), 32'(st), 32'(tbl[i].tgt));
    end

    for (int n = 0; n < 40; n++) begin
      bit           im = 1'($urandom);
      int           m  = int'($urandom_range(1, 6));
      bit           br = 1'($urandom);
      logic [D-1:0] tg = D'($urandom);
      run_instr(im, m, br, tg, -1, len, mc, sl, st);
      check($sformatf("rnd%0d latency", n), 32'(len), 32'(E + 4 + (im ? m : 0)));
      check($sformatf("rnd%0d mem_req cycles", n), 32'(mc), 32'(im ? m : 0));
      check($sformatf("rnd%0d pc_load", n), 32'(sl), 32'(br));
    end

    // Halt in DECODE wins over is_mem/branch; HALTED ignores start.
    run_instr(0, 0, 0, '0, 1, len, mc, sl, st);
    start = 1'b0; halt = 1'b1; is_mem = 1'b1; branch_taken = 1'b1; mem_ready = 1'b1;
    step();
    check("halted outputs", 32'(dut_out()), 32'({ST_HALTED, 7'b0000001}));
    for (int i = 0; i < 4; i++) begin
      start = 1'b1; halt = 1'($urandom);
      step();
      start = 1'b0;
      step();
      check($sformatf("halted sticky %0d", i), 32'(dut_out()), 32'({ST_HALTED, 7'b0000001}));
    end

    // Asynchronous reset in the second MEM cycle, between edges.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    run_instr(1, 10, 1, 12'h5A5, E + 3, len, mc, sl, st);
    drive(E + 3, 1, 10, 1, 12'h5A5);
    #3 reset = 1'b0;
    #1 check("async reset mid-MEM", {dut_out(), pc_target}, 32'd0);
    start = 1'b0;
    #2 reset = 1'b1;
    step();
    check("idle after mid reset", 32'(dut_out()), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    run_instr(0, 0, 0, '0, -1, len, mc, sl, st);
    check("clean instr after reset", 32'(len), 32'(8));
    check("no stale branch", 32'(sl), 32'd0);

`ifdef SEQ_PERF_EN
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, '0, -1, len, mc, sl, st);
    check("instr_retired", 32'(instr_retired), 32'd3);
    check("cycle_count", 32'(cycle_count), 32'd24);
    run_instr(1, 100000, 0, '0, E + 2, len, mc, sl, st);
    for (int i = 0; i < 70000; i++) begin
      drive(E + 2, 1, 100000, 0, '0);
      step();
    end
    check("cycle_count saturates", 32'(cycle_count), 32'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
